// File: rtl/button_debounce.sv
// Debouncer for an active-low, pulled-up push button: 2-FF synchroniser, 4-state
// accept/reject FSM, press/release strobes, wrapping press counter. BUTTON_LONG_PRESS_EN adds long_pulse.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 12000,
    parameter int unsigned COUNT_W         = 8,
    parameter int unsigned LONG_CYCLES     = 6000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pin_n,
    output logic               pressed,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic [COUNT_W-1:0] press_count,
    output logic               long_pulse,
    output logic [1:0]         state_dbg_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_check
        $error("button_debounce: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    // Valid/ready does not apply here: every output is a registered level or a
    // one-cycle strobe that consumers sample on any rising clk edge.

    // Synchroniser resets to the released (pulled-up) level.
    logic sync1_q;
    logic sync2_q;
    logic s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= pin_n;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               pressed_q;
    logic               pressed_d;
    logic               press_pulse_q;
    logic               press_pulse_d;
    logic               release_pulse_q;
    logic               release_pulse_d;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pressed_d       = pressed_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        count_d         = count_q;
        case (state_q)
            IDLE: begin
                if (!s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = HELD;
                    cnt_d         = '0;
                    pressed_d     = 1'b1;
                    press_pulse_d = 1'b1;
                    count_d       = count_q + COUNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (!s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d         = IDLE;
                    cnt_d           = '0;
                    pressed_d       = 1'b0;
                    release_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            count_q         <= count_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign press_count   = count_q;
    assign state_dbg_o   = state_q;

`ifdef BUTTON_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

    logic              enter_held;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              long_q;
    logic              long_d;

    // Only a fresh acceptance clears the hold timer; a rejected release keeps it.
    assign enter_held = (state_q == PRESS_WAIT) && (state_d == HELD);

    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (enter_held) begin
            hold_d = '0;
        end else if (state_q == HELD && hold_q != HOLD_SAT) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (hold_q == HOLD_FIRE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_pulse = long_q;
`else
    assign long_pulse = 1'b0;
`endif

endmodule
